// File: rtl/decimal_entry_alu_if.sv
// Keypad/result bus for decimal_entry_alu.
// The keypad side drives the strobes; the ALU side drives operands, result and status.
interface decimal_entry_alu_if #(
  parameter int WIDTH = 16
);
  logic             digit_valid;
  logic [3:0]       digit;
  logic             op_valid;
  logic [1:0]       op_code;
  logic             backspace;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] result;
  logic             negative;
  logic             overflow;
  logic             result_valid;
  logic             digit_reject;
  logic [1:0]       state;
  logic [2:0]       digit_count;

  modport master (
    output digit_valid, digit, op_valid, op_code, backspace,
    input  operand_a, operand_b, result, negative, overflow,
           result_valid, digit_reject, state, digit_count
  );

  modport slave (
    input  digit_valid, digit, op_valid, op_code, backspace,
    output operand_a, operand_b, result, negative, overflow,
           result_valid, digit_reject, state, digit_count
  );
endinterface

// File: rtl/decimal_entry_alu.sv
// Decimal keypad entry with two-operand add/subtract.
// Digits build operand A, an operator switches entry to operand B, equals
// produces a registered result with sign/overflow flags.
// Optional macro DECIMAL_ENTRY_ALU_CHAIN_EN: an add/subtract key pressed while a
// result is shown chains that result (as magnitude) into operand A.
module decimal_entry_alu #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 4
) (
  input logic                clock,
  input logic                reset,
  decimal_entry_alu_if.slave bus
);

  typedef enum logic [1:0] {
    ENTER_A = 2'b00,
    ENTER_B = 2'b01,
    RESULT  = 2'b10
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_EQ  = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;
  localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

  state_t           st, st_n;
  logic [WIDTH-1:0] a, a_n, b, b_n, res, res_n;
  logic             neg, neg_n, ovf, ovf_n, rv, rv_n, rej, rej_n, sub, sub_n;
  logic [2:0]       cnt, cnt_n;

  logic [WIDTH-1:0] cur, cur_x10, cur_div10;
  logic [WIDTH:0]   sum;
  logic             digit_ok, is_clear;

  // Next-state and datapath decode; clear > other op > backspace > digit
  always_comb begin
    st_n  = st;
    a_n   = a;
    b_n   = b;
    res_n = res;
    neg_n = neg;
    ovf_n = ovf;
    rv_n  = rv;
    rej_n = 1'b0;
    sub_n = sub;
    cnt_n = cnt;

    cur       = (st == ENTER_B) ? b : a;
    cur_x10   = (cur << 3) + (cur << 1) + WIDTH'(bus.digit);
    cur_div10 = cur / WIDTH'(10);
    sum       = {1'b0, a} + {1'b0, b};
    digit_ok  = (bus.digit <= 4'd9);
    is_clear  = bus.op_valid && (bus.op_code == OP_CLR);

    if (is_clear) begin
      st_n  = ENTER_A;
      a_n   = '0;
      b_n   = '0;
      res_n = '0;
      neg_n = 1'b0;
      ovf_n = 1'b0;
      rv_n  = 1'b0;
      sub_n = 1'b0;
      cnt_n = '0;
    end else if (bus.op_valid) begin
      case (st)
        ENTER_A: begin
          if (bus.op_code != OP_EQ) begin
            sub_n = (bus.op_code == OP_SUB);
            st_n  = ENTER_B;
            cnt_n = '0;
            b_n   = '0;
          end
        end
        ENTER_B: begin
          if (bus.op_code == OP_EQ) begin
            st_n = RESULT;
            rv_n = 1'b1;
            if (sub) begin
              ovf_n = 1'b0;
              if (a >= b) begin
                res_n = a - b;
                neg_n = 1'b0;
              end else begin
                res_n = b - a;
                neg_n = 1'b1;
              end
            end else begin
              res_n = sum[WIDTH-1:0];
              ovf_n = sum[WIDTH];
              neg_n = 1'b0;
            end
          end else begin
            sub_n = (bus.op_code == OP_SUB);
          end
        end
        RESULT: begin
`ifdef DECIMAL_ENTRY_ALU_CHAIN_EN
          if (bus.op_code == OP_ADD || bus.op_code == OP_SUB) begin
            a_n   = res;
            sub_n = (bus.op_code == OP_SUB);
            b_n   = '0;
            cnt_n = '0;
            rv_n  = 1'b0;
            neg_n = 1'b0;
            st_n  = ENTER_B;
          end
`else
          st_n = RESULT;
`endif
        end
        default: st_n = ENTER_A;
      endcase
    end else if (bus.backspace) begin
      if (st != RESULT && cnt != 3'd0) begin
        if (st == ENTER_B) b_n = cur_div10;
        else               a_n = cur_div10;
        cnt_n = cnt - 3'd1;
      end
    end else if (bus.digit_valid) begin
      if (st == RESULT) begin
        if (digit_ok) begin
          a_n   = WIDTH'(bus.digit);
          b_n   = '0;
          cnt_n = 3'd1;
          rv_n  = 1'b0;
          st_n  = ENTER_A;
        end else begin
          rej_n = 1'b1;
        end
      end else if (digit_ok && cnt < MAX_CNT) begin
        if (st == ENTER_B) b_n = cur_x10;
        else               a_n = cur_x10;
        cnt_n = cnt + 3'd1;
      end else begin
        rej_n = 1'b1;
      end
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      st  <= ENTER_A;
      a   <= '0;
      b   <= '0;
      res <= '0;
      neg <= 1'b0;
      ovf <= 1'b0;
      rv  <= 1'b0;
      rej <= 1'b0;
      sub <= 1'b0;
      cnt <= '0;
    end else begin
      st  <= st_n;
      a   <= a_n;
      b   <= b_n;
      res <= res_n;
      neg <= neg_n;
      ovf <= ovf_n;
      rv  <= rv_n;
      rej <= rej_n;
      sub <= sub_n;
      cnt <= cnt_n;
    end
  end

  assign bus.operand_a    = a;
  assign bus.operand_b    = b;
  assign bus.result       = res;
  assign bus.negative     = neg;
  assign bus.overflow     = ovf;
  assign bus.result_valid = rv;
  assign bus.digit_reject = rej;
  assign bus.state        = st;
  assign bus.digit_count  = cnt;

endmodule

// File: tb/tb_decimal_entry_alu.sv
// Bench for decimal_entry_alu: three instances (16/4, 8/2, 4/1) share one
// stimulus stream and are checked every cycle against an arithmetic model.
module tb_decimal_entry_alu;

  localparam int N = 3;
  int W [N] = '{16, 8, 4};
  int M [N] = '{4, 2, 1};

  logic       clock = 1'b0;
  logic       reset;
  logic       dv, ov, bs;
  logic [3:0] dg;
  logic [1:0] oc;

  logic [15:0] d_a [N];
  logic [15:0] d_b [N];
  logic [15:0] d_res [N];
  logic        d_neg [N];
  logic        d_ovf [N];
  logic        d_rv [N];
  logic        d_rej [N];
  logic [1:0]  d_st [N];
  logic [2:0]  d_cnt [N];

  int m_a [N], m_b [N], m_res [N], m_neg [N], m_ovf [N];
  int m_rv [N], m_rej [N], m_st [N], m_cnt [N], m_sub [N];

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < N; g++) begin : u
    localparam int GW = (g == 0) ? 16 : (g == 1) ? 8 : 4;
    localparam int GM = (g == 0) ? 4 : (g == 1) ? 2 : 1;
    decimal_entry_alu_if #(.WIDTH(GW)) bus ();
    decimal_entry_alu #(.WIDTH(GW), .MAX_DIGITS(GM)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
    );
    assign bus.digit_valid = dv;
    assign bus.digit       = dg;
    assign bus.op_valid    = ov;
    assign bus.op_code     = oc;
    assign bus.backspace   = bs;
    assign d_a[g]   = 16'(bus.operand_a);
    assign d_b[g]   = 16'(bus.operand_b);
    assign d_res[g] = 16'(bus.result);
    assign d_neg[g] = bus.negative;
    assign d_ovf[g] = bus.overflow;
    assign d_rv[g]  = bus.result_valid;
    assign d_rej[g] = bus.digit_reject;
    assign d_st[g]  = bus.state;
    assign d_cnt[g] = bus.digit_count;
  end

  task automatic cmp(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[inst %0d]: got %0d expected %0d at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic zero(input int k);
    m_a[k] = 0; m_b[k] = 0; m_res[k] = 0; m_neg[k] = 0; m_ovf[k] = 0;
    m_rv[k] = 0; m_st[k] = 0; m_cnt[k] = 0; m_sub[k] = 0;
  endtask

  // Behavioural model: one key event per cycle, acted on by priority
  task automatic step(input int k, input bit r, input bit dvi, input int dgi,
                      input bit ovi, input int oci, input bit bsi);
    int mask = (1 << W[k]) - 1;
    m_rej[k] = 0;
    if (r || (ovi && oci == 3)) begin
      zero(k);
    end else if (ovi) begin
      if (oci != 2) begin
        if (m_st[k] == 0) begin
          m_sub[k] = oci; m_st[k] = 1; m_cnt[k] = 0; m_b[k] = 0;
        end else if (m_st[k] == 1) begin
          m_sub[k] = oci;
        end else begin
`ifdef DECIMAL_ENTRY_ALU_CHAIN_EN
          m_a[k] = m_res[k]; m_sub[k] = oci; m_b[k] = 0; m_cnt[k] = 0;
          m_rv[k] = 0; m_neg[k] = 0; m_st[k] = 1;
`endif
        end
      end else if (m_st[k] == 1) begin
        if (m_sub[k] == 0) begin
          m_res[k] = (m_a[k] + m_b[k]) & mask;
          m_ovf[k] = (m_a[k] + m_b[k]) > mask;
          m_neg[k] = 0;
        end else begin
          m_res[k] = (m_a[k] >= m_b[k]) ? m_a[k] - m_b[k] : m_b[k] - m_a[k];
          m_neg[k] = (m_a[k] < m_b[k]);
          m_ovf[k] = 0;
        end
        m_rv[k] = 1; m_st[k] = 2;
      end
    end else if (bsi) begin
      if (m_st[k] != 2 && m_cnt[k] > 0) begin
        if (m_st[k] == 1) m_b[k] = m_b[k] / 10;
        else              m_a[k] = m_a[k] / 10;
        m_cnt[k]--;
      end
    end else if (dvi) begin
      if (m_st[k] == 2) begin
        if (dgi <= 9) begin
          m_a[k] = dgi; m_b[k] = 0; m_cnt[k] = 1; m_rv[k] = 0; m_st[k] = 0;
        end else m_rej[k] = 1;
      end else if (dgi <= 9 && m_cnt[k] < M[k]) begin
        if (m_st[k] == 1) m_b[k] = m_b[k] * 10 + dgi;
        else              m_a[k] = m_a[k] * 10 + dgi;
        m_cnt[k]++;
      end else m_rej[k] = 1;
    end
  endtask

  // Per-cycle comparison of every instance against the model
  always @(negedge clock) begin
    if (cmp_en) begin
      for (int k = 0; k < N; k++) begin
        cmp("operand_a", k, d_a[k], m_a[k]);
        cmp("operand_b", k, d_b[k], m_b[k]);
        cmp("result", k, d_res[k], m_res[k]);
        cmp("negative", k, d_neg[k], m_neg[k]);
        cmp("overflow", k, d_ovf[k], m_ovf[k]);
        cmp("result_valid", k, d_rv[k], m_rv[k]);
        cmp("digit_reject", k, d_rej[k], m_rej[k]);
        cmp("state", k, d_st[k], m_st[k]);
        cmp("digit_count", k, d_cnt[k], m_cnt[k]);
      end
    end
  end

  task automatic cyc(input bit r, input bit dvi, input int dgi, input bit ovi, input int oci, input bit bsi);
    reset = r; dv = dvi; dg = 4'(dgi); ov = ovi; oc = 2'(oci); bs = bsi;
    @(posedge clock);
    for (int k = 0; k < N; k++) step(k, r, dvi, dgi, ovi, oci, bsi);
    #1;
  endtask

  task automatic dig(input int d);  cyc(0, 1, d, 0, 0, 0); endtask
  task automatic op(input int c);   cyc(0, 0, 0, 1, c, 0); endtask
  task automatic bsp();             cyc(0, 0, 0, 0, 0, 1); endtask
  task automatic idle();            cyc(0, 0, 0, 0, 0, 0); endtask

  initial begin
    bit any_res;
    int dgr;
    for (int k = 0; k < N; k++) begin zero(k); m_rej[k] = 0; end
    // reset with strobes active
    cyc(1, 1, 5, 1, 0, 1);
    cmp_en = 1'b1;
    cyc(1, 1, 7, 0, 0, 1);
    for (int k = 0; k < N; k++) begin
      cmp("lit_reset_a", k, d_a[k], 0);
      cmp("lit_reset_state", k, d_st[k], 0);
      cmp("lit_reset_rv", k, d_rv[k], 0);
    end

    // 46 + 327
    idle();
    dig(4); dig(6); op(0); dig(3); dig(2); dig(7);
    cmp("lit_rv_before_eq", 0, d_rv[0], 0);
    op(2);
    cmp("lit_373", 0, d_res[0], 373);
    cmp("lit_373_model", 0, m_res[0], 373);
    cmp("lit_373_a", 0, d_a[0], 46);
    cmp("lit_373_b", 0, d_b[0], 327);
    cmp("lit_373_rv", 0, d_rv[0], 1);
    cmp("lit_373_state", 0, d_st[0], 2);
    cmp("lit_373_ovf", 0, d_ovf[0], 0);

    // 99 + 99 on all widths
    op(3); dig(9); dig(9); op(0); dig(9); dig(9); op(2);
    cmp("lit_198", 1, d_res[1], 198);
    cmp("lit_198_ovf", 1, d_ovf[1], 0);
    cmp("lit_9p9_w4", 2, d_res[2], 2);
    cmp("lit_9p9_w4_model", 2, m_res[2], 2);
    cmp("lit_9p9_w4_ovf", 2, d_ovf[2], 1);

    // 12 - 57
    op(3); dig(1); dig(2); op(1); dig(5); dig(7); op(2);
    cmp("lit_45", 1, d_res[1], 45);
    cmp("lit_45_neg", 1, d_neg[1], 1);

    // digit limit, invalid digit, backspace to empty
    op(3); dig(9); dig(9); dig(9); dig(9);
    cmp("lit_no_rej", 0, d_rej[0], 0);
    dig(5);
    cmp("lit_rej5", 0, d_rej[0], 1);
    cmp("lit_9999", 0, d_a[0], 9999);
    idle();
    cmp("lit_rej_pulse", 0, d_rej[0], 0);
    dig(12);
    cmp("lit_rej12", 0, d_rej[0], 1);
    bsp(); bsp(); bsp(); bsp();
    cmp("lit_bs_a", 0, d_a[0], 0);
    cmp("lit_bs_cnt", 0, d_cnt[0], 0);
    bsp();
    cmp("lit_bs5_rej", 0, d_rej[0], 0);
    cmp("lit_bs5_cnt", 0, d_cnt[0], 0);

    // clear and digit together
    dig(7);
    cyc(0, 1, 5, 1, 3, 0);
    cmp("lit_clr_a", 0, d_a[0], 0);
    cmp("lit_clr_cnt", 0, d_cnt[0], 0);

    // chaining
    op(3); dig(5); op(0); dig(3); op(2);
    cmp("lit_8", 0, d_res[0], 8);
    op(1);
`ifdef DECIMAL_ENTRY_ALU_CHAIN_EN
    cmp("lit_chain_a", 0, d_a[0], 8);
    cmp("lit_chain_state", 0, d_st[0], 1);
    dig(2); op(2);
    cmp("lit_chain_6", 0, d_res[0], 6);
    cmp("lit_chain_6_w4", 2, d_res[2], 6);
`else
    cmp("lit_nochain_state", 0, d_st[0], 2);
    dig(2);
    cmp("lit_nochain_a", 0, d_a[0], 2);
    cmp("lit_nochain_state2", 0, d_st[0], 0);
    cmp("lit_nochain_rv", 0, d_rv[0], 0);
    op(2);
    cmp("lit_nochain_res", 0, d_res[0], 8);
`endif

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      any_res = 0;
      for (int k = 0; k < N; k++) if (m_st[k] == 2) any_res = 1;
      dgr = (!any_res && $urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15))
                                                   : int'($urandom_range(0, 9));
      cyc($urandom_range(0, 299) == 0,
          $urandom_range(0, 9) < 4,
          dgr,
          $urandom_range(0, 9) < 2,
          ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2)),
          $urandom_range(0, 9) == 0);
    end
    idle();
    @(negedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decimal_entry_alu.md
Name: decimal_entry_alu

Overview:
- Keypad-driven decimal entry and arithmetic unit for the calculator datapath.
- Accepts one BCD digit per strobe and builds operand A, then operand B after an operator key, in the same shift-by-ten way as the single-operand accumulator.
- On "equals" it produces a registered add/subtract result with sign and overflow flags.
- Parametrised in operand width and digit limit. Adds backspace, clear, digit rejection and an explicit entry state machine.

Parameters:
- WIDTH, 16, bit width of operands and result magnitude.
- MAX_DIGITS, 4, maximum decimal digits accepted per operand; must satisfy 10^MAX_DIGITS - 1 < 2^WIDTH.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- digit_valid  input  1  one-cycle strobe; digit is valid.
- digit  input  4  BCD digit 0..9.
- op_valid  input  1  one-cycle strobe; op_code is valid.
- op_code  input  2  00 add, 01 subtract, 10 equals, 11 clear.
- backspace  input  1  one-cycle strobe; delete last digit of the current operand.
- operand_a  output  WIDTH  operand A register.
- operand_b  output  WIDTH  operand B register.
- result  output  WIDTH  result magnitude.
- negative  output  1  result is negative (subtract with B > A).
- overflow  output  1  add carry-out beyond WIDTH bits.
- result_valid  output  1  result/negative/overflow are current.
- digit_reject  output  1  one-cycle pulse: last digit strobe was dropped.
- state  output  2  00 ENTER_A, 01 ENTER_B, 10 RESULT.
- digit_count  output  3  digits held in the current operand.

Behaviour:
- Reset is synchronous. On a clock edge with reset=1, all outputs go to 0 and state goes to ENTER_A. Reset overrides any strobe in the same cycle.
- Same-cycle priority: clear > other op > backspace > digit. Only the highest-priority event is acted on.
- Digit accept, in ENTER_A or ENTER_B:
  - Condition: digit <= 9 and digit_count < MAX_DIGITS.
  - Action: current operand <= operand*10 + digit, computed as (x<<3)+(x<<1)+digit; digit_count increments.
  - Otherwise the operand is unchanged and digit_reject pulses for one cycle, one cycle after the strobe.
- Backspace, in ENTER_A or ENTER_B with digit_count > 0: operand <= operand/10 and digit_count decrements. At count 0 it is ignored with no flag.
- Operator add or subtract:
  - In ENTER_A: latch the operator, go to ENTER_B, digit_count <= 0, operand_b <= 0.
  - In ENTER_B: replace the latched operator; operand B is untouched.
- Equals:
  - In ENTER_B: compute on the next edge and go to RESULT; result_valid <= 1. Latency is one cycle from the op_valid edge to result_valid=1.
  - In ENTER_A: ignored.
- Add: result = (A+B) mod 2^WIDTH, overflow = carry out, negative = 0.
- Subtract:
  - If A >= B: result = A-B, negative = 0.
  - Otherwise: result = B-A, negative = 1.
  - overflow = 0.
- Clear in any state: operands, result and flags go to 0, digit_count to 0, state to ENTER_A. This takes one cycle.
- In RESULT:
  - A digit strobe starts a fresh entry. In the same cycle: A <= digit, B <= 0, digit_count <= 1, result_valid <= 0, state <= ENTER_A.
  - Backspace is ignored.
  - Operators behave as defined under the optional feature.
- result, negative and overflow hold their values until the next equals, clear or reset.
- digit_count saturates within 0..MAX_DIGITS and never wraps.

Optional Feature:
- Macro: DECIMAL_ENTRY_ALU_CHAIN_EN.
- Defined: an add/subtract op in RESULT loads operand_a <= result, latches the operator, clears B, sets digit_count <= 0, sets result_valid <= 0 and goes to ENTER_B. A negative result is chained as its magnitude, and negative is cleared.
- Not defined: add/subtract ops in RESULT are ignored. Only a digit, clear or reset leaves RESULT.

Test Plan:
- Reset held 2 cycles, then released -> every output 0, state 00. Strobes asserted during reset have no effect.
- Digits 4,6, op add, digits 3,2,7, equals -> A=46, B=327, result=373, negative=0, overflow=0, result_valid=1 exactly one cycle after the equals strobe, state 10.
- MAX_DIGITS=4: digits 9,9,9,9,5 -> A=9999, fifth digit dropped, digit_reject pulses once; digit=12 -> rejected. Backspace x5 -> A=0, count 0, no flag on the fifth backspace.
- WIDTH=8, MAX_DIGITS=2: 99 add 99 equals -> result=198, overflow=0. 12 sub 57 equals -> result=45, negative=1.
- WIDTH=4, MAX_DIGITS=1: 9 add 9 equals -> result=2, overflow=1. Clear and digit in the same cycle -> clear wins, all zero.
- CHAIN_EN defined: 5 add 3 equals, then sub, 2, equals -> result=6. CHAIN_EN undefined: same stimulus -> sub is ignored; digit 2 restarts entry with A=2, state 00.
